// File: rtl/pipe_ctrl_if.sv
// Decode-field inputs and staged control outputs of the RV32I pipeline control unit.
// The master side drives instruction fields; the slave side (pipe_ctrl) returns the bundle.
interface pipe_ctrl_if #(
  parameter int ALUCTRL_W = 4
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic                 FlushE;

  logic [2:0]           ImmSrcD;
  logic                 IllegalD;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [1:0]           ALUASrcE;
  logic                 ALUBSrcE;
  logic                 BranchE;
  logic                 JumpE;
  logic                 PCTargetALUSrcE;
  logic [1:0]           ResultSrcE;
  logic                 MulDivE;
  logic [2:0]           MdOpE;
  logic                 BusyE;
  logic                 RegWriteM;
  logic [1:0]           MemWriteM;
  logic [2:0]           LoadSizeM;
  logic [1:0]           ResultSrcM;
  logic                 RegWriteW;
  logic [1:0]           ResultSrcW;

  modport master (
    output op, funct3, funct7, FlushE,
    input  ImmSrcD, IllegalD, ALUControlE, ALUASrcE, ALUBSrcE, BranchE, JumpE,
           PCTargetALUSrcE, ResultSrcE, MulDivE, MdOpE, BusyE, RegWriteM,
           MemWriteM, LoadSizeM, ResultSrcM, RegWriteW, ResultSrcW
  );

  modport slave (
    input  op, funct3, funct7, FlushE,
    output ImmSrcD, IllegalD, ALUControlE, ALUASrcE, ALUBSrcE, BranchE, JumpE,
           PCTargetALUSrcE, ResultSrcE, MulDivE, MdOpE, BusyE, RegWriteM,
           MemWriteM, LoadSizeM, ResultSrcM, RegWriteW, ResultSrcW
  );
endinterface

// File: rtl/pipe_ctrl.sv
// RV32I pipelined control unit: decode plus E/M/W control registers with flush, bubble and hold.
// Define RV32M_EN to decode RV32M and enable the multi-cycle divide occupancy counter.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int ALUCTRL_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);

  if (DIV_CYCLES < 1 || ALUCTRL_W < 4) begin : g_param_check
    $error("pipe_ctrl: DIV_CYCLES must be >= 1 and ALUCTRL_W >= 4");
  end

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           mem_write;
    logic [2:0]           load_size;
    logic [1:0]           result_src;
    logic                 branch;
    logic                 jump;
    logic                 pctarget;
    logic [1:0]           alu_a_src;
    logic                 alu_b_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 muldiv;
    logic [2:0]           md_op;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_write;
    logic [2:0] load_size;
    logic [1:0] result_src;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  ctrl_e_t    dec;
  logic [2:0] imm_src;
  logic       illegal;
  logic       busy;

  ctrl_e_t e_reg;
  ctrl_m_t m_reg;
  ctrl_m_t m_next;
  ctrl_w_t w_reg;

  // funct3 -> ALU operation; alt selects sub (000) or sra (101).
  function automatic logic [ALUCTRL_W-1:0] alu_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? 4'd1 : 4'd0;
      3'b001:  code = 4'd7;
      3'b010:  code = 4'd5;
      3'b011:  code = 4'd6;
      3'b100:  code = 4'd4;
      3'b101:  code = alt ? 4'd9 : 4'd8;
      3'b110:  code = 4'd3;
      default: code = 4'd2;
    endcase
    return ALUCTRL_W'(code);
  endfunction

  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    illegal = 1'b0;
    case (bus.op)
      OP_R: begin
        if (bus.funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec.reg_write  = 1'b1;
          dec.muldiv     = 1'b1;
          dec.md_op      = bus.funct3;
          dec.result_src = 2'b11;
`else
          illegal = 1'b1;
`endif
        end else begin
          dec.reg_write   = 1'b1;
          dec.alu_control = alu_decode(bus.funct3, bus.funct7[5]);
        end
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_b_src   = 1'b1;
        // Only srai takes funct7[5]; for other I-ops that bit is immediate data.
        dec.alu_control = alu_decode(bus.funct3, bus.funct7[5] && (bus.funct3 == 3'b101));
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_b_src  = 1'b1;
        dec.result_src = 2'b01;
        dec.load_size  = bus.funct3;
        illegal = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
      end
      OP_STORE: begin
        imm_src       = 3'b001;
        dec.alu_b_src = 1'b1;
        dec.mem_write = bus.funct3[1:0] + 2'b01;
        illegal       = (bus.funct3 >= 3'b011);
      end
      OP_BR: begin
        imm_src         = 3'b010;
        dec.branch      = 1'b1;
        dec.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        imm_src        = 3'b011;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.pctarget   = 1'b1;
        dec.alu_b_src  = 1'b1;
        dec.result_src = 2'b10;
      end
      OP_LUI: begin
        imm_src       = 3'b100;
        dec.reg_write = 1'b1;
        dec.alu_a_src = 2'b10;
        dec.alu_b_src = 1'b1;
      end
      OP_AUIPC: begin
        imm_src       = 3'b100;
        dec.reg_write = 1'b1;
        dec.alu_a_src = 2'b01;
        dec.alu_b_src = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) dec = '0;
  end

  assign bus.ImmSrcD  = imm_src;
  assign bus.IllegalD = illegal;

`ifdef RV32M_EN
  localparam int                CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             div_load;

  // A flushed divide never enters E, so it must not start the counter either.
  assign div_load = !bus.FlushE && dec.muldiv && bus.funct3[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end else if (div_load) begin
      cnt_reg <= CNT_LOAD;
    end
  end

  assign busy = (cnt_reg != '0);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_reg <= '0;
    end else if (!busy) begin
      e_reg <= bus.FlushE ? '0 : dec;
    end
  end

  // While E is held the divide stays put, so M receives bubbles.
  always_comb begin
    m_next = '0;
    if (!busy) begin
      m_next.reg_write  = e_reg.reg_write;
      m_next.mem_write  = e_reg.mem_write;
      m_next.load_size  = e_reg.load_size;
      m_next.result_src = e_reg.result_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reg <= '0;
      w_reg <= '0;
    end else begin
      m_reg            <= m_next;
      w_reg.reg_write  <= m_reg.reg_write;
      w_reg.result_src <= m_reg.result_src;
    end
  end

  assign bus.ALUControlE     = e_reg.alu_control;
  assign bus.ALUASrcE        = e_reg.alu_a_src;
  assign bus.ALUBSrcE        = e_reg.alu_b_src;
  assign bus.BranchE         = e_reg.branch;
  assign bus.JumpE           = e_reg.jump;
  assign bus.PCTargetALUSrcE = e_reg.pctarget;
  assign bus.ResultSrcE      = e_reg.result_src;
  // Decode only sets these fields when RV32M is enabled, so they read 0 otherwise.
  assign bus.MulDivE         = e_reg.muldiv;
  assign bus.MdOpE           = e_reg.md_op;
  assign bus.BusyE           = busy;
  assign bus.RegWriteM       = m_reg.reg_write;
  assign bus.MemWriteM       = m_reg.mem_write;
  assign bus.LoadSizeM       = m_reg.load_size;
  assign bus.ResultSrcM      = m_reg.result_src;
  assign bus.RegWriteW       = w_reg.reg_write;
  assign bus.ResultSrcW      = w_reg.result_src;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (DIV_CYCLES=4); RV32M_EN selects the RV32M scenarios.
module tb_pipe_ctrl;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MD    = 7'b0000001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipe_ctrl_if #(.ALUCTRL_W(4)) bus ();
  pipe_ctrl #(.DIV_CYCLES(4), .ALUCTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] all_ewm;
  assign all_ewm = {bus.ALUControlE, bus.ALUASrcE, bus.ALUBSrcE, bus.BranchE, bus.JumpE,
                    bus.PCTargetALUSrcE, bus.ResultSrcE, bus.MulDivE, bus.MdOpE, bus.BusyE,
                    bus.RegWriteM, bus.MemWriteM, bus.LoadSizeM, bus.ResultSrcM,
                    bus.RegWriteW, bus.ResultSrcW};

  task automatic drv(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic fl);
    bus.op = o; bus.funct3 = f3; bus.funct7 = f7; bus.FlushE = fl;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drv(OP_R, 3'b000, F7_ALT, 1'b0);
    step();
    checks++; if (all_ewm !== 32'd0) begin failures++; $display("FAIL reset_state got=%h exp=0", all_ewm); end
    reset = 1'b1;
    step();
    checks++; if (bus.ALUControlE !== 4'd1) begin failures++; $display("FAIL reset_first_e got=%0d exp=1", bus.ALUControlE); end
  endtask

  task automatic test_add_store();
    drv(OP_R, 3'b000, 7'd0, 1'b0); #1;
    checks++; if (bus.IllegalD !== 1'b0) begin failures++; $display("FAIL add_illegal got=%b exp=0", bus.IllegalD); end
    step();
    checks++; if (bus.ALUControlE !== 4'd0 || bus.ResultSrcE !== 2'b00) begin failures++; $display("FAIL add_e got=%0d/%b exp=0/00", bus.ALUControlE, bus.ResultSrcE); end
    drv(OP_STORE, 3'b010, 7'd0, 1'b0);
    step();
    checks++; if (bus.RegWriteM !== 1'b1 || bus.ALUBSrcE !== 1'b1) begin failures++; $display("FAIL add_m got=%b/%b exp=1/1", bus.RegWriteM, bus.ALUBSrcE); end
    drv(OP_I, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.RegWriteW !== 1'b1 || bus.MemWriteM !== 2'b11 || bus.RegWriteM !== 1'b0) begin
      failures++; $display("FAIL add_w_sw_m got=%b/%b/%b exp=1/11/0", bus.RegWriteW, bus.MemWriteM, bus.RegWriteM); end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops [12] = '{OP_R, OP_R, OP_I, OP_I, OP_I, OP_R, OP_R, OP_R, OP_I, OP_I, OP_R, OP_R};
    logic [2:0] f3s [12] = '{3'd0, 3'd5, 3'd5, 3'd5, 3'd0, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};
    logic [6:0] f7s [12] = '{F7_ALT, F7_ALT, F7_ALT, 7'd0, F7_ALT, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
    logic [3:0] exp [12] = '{4'd1, 4'd9, 4'd9, 4'd8, 4'd0, 4'd6, 4'd2, 4'd3, 4'd4, 4'd7, 4'd5, 4'd8};
    for (int i = 0; i < 12; i++) begin
      drv(ops[i], f3s[i], f7s[i], 1'b0);
      step();
      checks++; if (bus.ALUControlE !== exp[i]) begin failures++; $display("FAIL alu_decode[%0d] got=%0d exp=%0d", i, bus.ALUControlE, exp[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [6] = '{OP_BAD, OP_LOAD, OP_LOAD, OP_STORE, OP_STORE, OP_LOAD};
    logic [2:0] f3s [6] = '{3'd0, 3'd3, 3'd6, 3'd3, 3'd2, 3'd5};
    logic       exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drv(ops[i], f3s[i], 7'd0, 1'b0); #1;
      checks++; if (bus.IllegalD !== exp[i]) begin failures++; $display("FAIL illegal_d[%0d] got=%b exp=%b", i, bus.IllegalD, exp[i]); end
    end
    drv(OP_STORE, 3'b010, 7'd0, 1'b0);
    step();
    drv(OP_STORE, 3'b011, 7'd0, 1'b0);
    step();
    checks++; if (bus.MemWriteM !== 2'b11) begin failures++; $display("FAIL illegal_prior_sw got=%b exp=11", bus.MemWriteM); end
    drv(OP_BAD, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.MemWriteM !== 2'b00 || bus.RegWriteM !== 1'b0) begin failures++; $display("FAIL illegal_sw_bubble got=%b/%b exp=00/0", bus.MemWriteM, bus.RegWriteM); end
    checks++; if ({bus.ALUControlE, bus.BranchE, bus.JumpE, bus.ResultSrcE, bus.ALUBSrcE} !== 9'd0) begin
      failures++; $display("FAIL illegal_e_bubble got=%0d/%b/%b exp=0/0/0", bus.ALUControlE, bus.BranchE, bus.JumpE); end
  endtask

  task automatic test_imm_jumps();
    logic [6:0] ops [8] = '{OP_I, OP_STORE, OP_BR, OP_JAL, OP_LUI, OP_AUIPC, OP_JALR, OP_LOAD};
    logic [2:0] exp [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0};
    for (int i = 0; i < 8; i++) begin
      drv(ops[i], 3'b000, 7'd0, 1'b0); #1;
      checks++; if (bus.ImmSrcD !== exp[i]) begin failures++; $display("FAIL imm_src[%0d] got=%b exp=%b", i, bus.ImmSrcD, exp[i]); end
    end
    drv(OP_JALR, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if ({bus.JumpE, bus.PCTargetALUSrcE, bus.ResultSrcE, bus.ALUBSrcE} !== 5'b11101) begin
      failures++; $display("FAIL jalr_e got=%b%b%b%b exp=11101", bus.JumpE, bus.PCTargetALUSrcE, bus.ResultSrcE, bus.ALUBSrcE); end
    drv(OP_JAL, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if ({bus.JumpE, bus.PCTargetALUSrcE, bus.ResultSrcE} !== 4'b1010) begin
      failures++; $display("FAIL jal_e got=%b%b%b exp=1010", bus.JumpE, bus.PCTargetALUSrcE, bus.ResultSrcE); end
    drv(OP_LUI, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.ALUASrcE !== 2'b10 || bus.ResultSrcM !== 2'b10) begin failures++; $display("FAIL lui_e got=%b/%b exp=10/10", bus.ALUASrcE, bus.ResultSrcM); end
    drv(OP_AUIPC, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.ALUASrcE !== 2'b01 || bus.JumpE !== 1'b0) begin failures++; $display("FAIL auipc_e got=%b/%b exp=01/0", bus.ALUASrcE, bus.JumpE); end
  endtask

  task automatic test_load();
    drv(OP_LOAD, 3'b001, 7'd0, 1'b0);
    step();
    checks++; if (bus.ResultSrcE !== 2'b01 || bus.ALUBSrcE !== 1'b1 || bus.ALUControlE !== 4'd0) begin
      failures++; $display("FAIL load_e got=%b/%b/%0d exp=01/1/0", bus.ResultSrcE, bus.ALUBSrcE, bus.ALUControlE); end
    drv(OP_I, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.LoadSizeM !== 3'b001 || bus.ResultSrcM !== 2'b01 || bus.RegWriteM !== 1'b1) begin
      failures++; $display("FAIL load_m got=%b/%b/%b exp=001/01/1", bus.LoadSizeM, bus.ResultSrcM, bus.RegWriteM); end
    step();
    checks++; if (bus.ResultSrcW !== 2'b01 || bus.RegWriteW !== 1'b1) begin failures++; $display("FAIL load_w got=%b/%b exp=01/1", bus.ResultSrcW, bus.RegWriteW); end
  endtask

  task automatic test_flush();
    drv(OP_R, 3'b000, 7'd0, 1'b0);
    step();
    drv(OP_BR, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.BranchE !== 1'b1 || bus.ALUControlE !== 4'd1 || bus.RegWriteM !== 1'b1) begin
      failures++; $display("FAIL beq_e got=%b/%0d/%b exp=1/1/1", bus.BranchE, bus.ALUControlE, bus.RegWriteM); end
    drv(OP_JAL, 3'b000, 7'd0, 1'b1);
    step();
    checks++; if (bus.BranchE !== 1'b0 || bus.JumpE !== 1'b0 || bus.RegWriteM !== 1'b0) begin
      failures++; $display("FAIL flush_e got=%b/%b/%b exp=0/0/0", bus.BranchE, bus.JumpE, bus.RegWriteM); end
    drv(OP_I, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.RegWriteM !== 1'b0 || bus.ResultSrcM !== 2'b00) begin failures++; $display("FAIL flush_m got=%b/%b exp=0/00", bus.RegWriteM, bus.ResultSrcM); end
  endtask

`ifdef RV32M_EN
  task automatic test_rv32m();
    drv(OP_R, 3'b000, F7_MD, 1'b0); #1;
    checks++; if (bus.IllegalD !== 1'b0) begin failures++; $display("FAIL mul_illegal got=%b exp=0", bus.IllegalD); end
    step();
    checks++; if (bus.MulDivE !== 1'b1 || bus.MdOpE !== 3'b000 || bus.BusyE !== 1'b0) begin
      failures++; $display("FAIL mul_e got=%b/%b/%b exp=1/000/0", bus.MulDivE, bus.MdOpE, bus.BusyE); end
    drv(OP_R, 3'b100, F7_MD, 1'b0);
    step();
    checks++; if (bus.BusyE !== 1'b1 || bus.MdOpE !== 3'b100 || bus.ResultSrcM !== 2'b11 || bus.RegWriteM !== 1'b1) begin
      failures++; $display("FAIL div_enter got=%b/%b/%b/%b exp=1/100/11/1", bus.BusyE, bus.MdOpE, bus.ResultSrcM, bus.RegWriteM); end
    drv(OP_R, 3'b000, 7'd0, 1'b1);
    step();
    checks++; if (bus.BusyE !== 1'b1 || bus.MulDivE !== 1'b1 || bus.MdOpE !== 3'b100 || bus.RegWriteM !== 1'b0) begin
      failures++; $display("FAIL div_hold1 got=%b/%b/%b/%b exp=1/1/100/0", bus.BusyE, bus.MulDivE, bus.MdOpE, bus.RegWriteM); end
    drv(OP_R, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.BusyE !== 1'b1 || bus.RegWriteM !== 1'b0) begin failures++; $display("FAIL div_hold2 got=%b/%b exp=1/0", bus.BusyE, bus.RegWriteM); end
    step();
    checks++; if (bus.BusyE !== 1'b0 || bus.MulDivE !== 1'b1 || bus.RegWriteM !== 1'b0) begin
      failures++; $display("FAIL div_release got=%b/%b/%b exp=0/1/0", bus.BusyE, bus.MulDivE, bus.RegWriteM); end
    step();
    checks++; if (bus.RegWriteM !== 1'b1 || bus.ResultSrcM !== 2'b11 || bus.MulDivE !== 1'b0 || bus.BusyE !== 1'b0) begin
      failures++; $display("FAIL div_in_m got=%b/%b/%b/%b exp=1/11/0/0", bus.RegWriteM, bus.ResultSrcM, bus.MulDivE, bus.BusyE); end
    drv(OP_R, 3'b011, F7_MD, 1'b0);
    step();
    checks++; if (bus.BusyE !== 1'b0 || bus.MdOpE !== 3'b011 || bus.ResultSrcW !== 2'b11) begin
      failures++; $display("FAIL mulhu_e got=%b/%b/%b exp=0/011/11", bus.BusyE, bus.MdOpE, bus.ResultSrcW); end
  endtask

  task automatic test_back_to_back();
    drv(OP_R, 3'b111, F7_MD, 1'b0);
    step();
    step();
    step();
    checks++; if (bus.BusyE !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", bus.BusyE); end
    step();
    checks++; if (bus.BusyE !== 1'b0 || bus.MdOpE !== 3'b111) begin failures++; $display("FAIL b2b_release got=%b/%b exp=0/111", bus.BusyE, bus.MdOpE); end
    drv(OP_R, 3'b110, F7_MD, 1'b0);
    step();
    checks++; if (bus.BusyE !== 1'b1 || bus.MdOpE !== 3'b110 || bus.RegWriteM !== 1'b1) begin
      failures++; $display("FAIL b2b_second got=%b/%b/%b exp=1/110/1", bus.BusyE, bus.MdOpE, bus.RegWriteM); end
    drv(OP_R, 3'b101, F7_MD, 1'b1);
    step(); step(); step();
    checks++; if (bus.BusyE !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", bus.BusyE); end
    step();
    checks++; if (bus.BusyE !== 1'b0 || bus.MulDivE !== 1'b0) begin failures++; $display("FAIL flushed_div got=%b/%b exp=0/0", bus.BusyE, bus.MulDivE); end
  endtask
`else
  task automatic test_rv32m();
    drv(OP_R, 3'b000, F7_MD, 1'b0); #1;
    checks++; if (bus.IllegalD !== 1'b1) begin failures++; $display("FAIL mul_illegal got=%b exp=1", bus.IllegalD); end
    step();
    checks++; if (bus.MulDivE !== 1'b0 || bus.BusyE !== 1'b0 || bus.ResultSrcE !== 2'b00) begin
      failures++; $display("FAIL mul_off_e got=%b/%b/%b exp=0/0/00", bus.MulDivE, bus.BusyE, bus.ResultSrcE); end
    drv(OP_R, 3'b100, F7_MD, 1'b0);
    step();
    checks++; if (bus.RegWriteM !== 1'b0 || bus.BusyE !== 1'b0 || bus.MdOpE !== 3'b000) begin
      failures++; $display("FAIL div_off got=%b/%b/%b exp=0/0/000", bus.RegWriteM, bus.BusyE, bus.MdOpE); end
    step();
    checks++; if (bus.BusyE !== 1'b0 || bus.RegWriteM !== 1'b0) begin failures++; $display("FAIL div_off_later got=%b/%b exp=0/0", bus.BusyE, bus.RegWriteM); end
  endtask
`endif

  task automatic test_reset_midstream();
    drv(OP_STORE, 3'b010, 7'd0, 1'b0);
    step();
`ifdef RV32M_EN
    drv(OP_R, 3'b101, F7_MD, 1'b0);
    step();
    checks++; if (bus.MemWriteM !== 2'b11 || bus.BusyE !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=11/1", bus.MemWriteM, bus.BusyE); end
`else
    drv(OP_JAL, 3'b000, 7'd0, 1'b0);
    step();
    checks++; if (bus.MemWriteM !== 2'b11 || bus.JumpE !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=11/1", bus.MemWriteM, bus.JumpE); end
`endif
    reset = 1'b0; #1;
    checks++; if (all_ewm !== 32'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", all_ewm); end
    drv(OP_R, 3'b000, F7_ALT, 1'b0);
    step();
    checks++; if (all_ewm !== 32'd0) begin failures++; $display("FAIL reset_held got=%h exp=0", all_ewm); end
    reset = 1'b1;
    step();
    checks++; if (bus.ALUControlE !== 4'd1 || bus.BusyE !== 1'b0 || bus.RegWriteM !== 1'b0) begin
      failures++; $display("FAIL post_reset got=%0d/%b/%b exp=1/0/0", bus.ALUControlE, bus.BusyE, bus.RegWriteM); end
  endtask

  initial begin
    drv(OP_I, 3'b000, 7'd0, 1'b0);
    test_reset();
    test_add_store();
    test_alu_decode();
    test_illegal();
    test_imm_jumps();
    test_load();
    test_flush();
    test_rv32m();
`ifdef RV32M_EN
    test_back_to_back();
`endif
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipelined control unit for the RV32I core. Decodes the Decode-stage instruction fields into the control bundle. Carries that bundle through the Execute, Memory and Writeback control registers, applying flush, bubble and hold. Optionally decodes RV32M and owns a multi-cycle divide occupancy counter that holds Execute until the divide retires.

## Interface
Parameters:
- DIV_CYCLES, 32: total cycles a divide/remainder occupies Execute (≥1).
- ALUCTRL_W, 4: ALUControl width (≥4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- FlushE  in  1  hazard-unit clear of the D→E register.
- ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational).
- IllegalD  out  1  unrecognised opcode/funct combination (combinational).
- ALUControlE  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- ALUASrcE  out  2  00 rs1, 01 PC, 10 zero.
- ALUBSrcE, BranchE, JumpE, PCTargetALUSrcE  out  1 each.
- ResultSrcE  out  2  exported for load-use detection.
- MulDivE  out  1  E holds an RV32M op.
- MdOpE  out  3  funct3 of the RV32M op.
- BusyE  out  1  divide occupying E; hazard unit must stall F/D.
- RegWriteM  out  1.
- MemWriteM  out  2  00 none, 01 sb, 10 sh, 11 sw.
- LoadSizeM  out  3  load funct3.
- ResultSrcM  out  2.
- RegWriteW  out  1.
- ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4, 11 MDU.

## Operation
- Decode by opcode:
  - R-type (0110011): ALUControl from funct3 plus funct7[5] (sub/sra).
  - I-ALU (0010011): ALUControl from funct3; funct7[5] honoured only for srai.
  - Load (0000011): ALUControl add, ALUBSrc=1, ResultSrc=01.
  - Store (0100011): MemWrite=funct3[1:0]+1, ImmSrc S.
  - Branch (1100011): Branch=1, ALUControl sub, ImmSrc B.
  - jal: Jump=1, ResultSrc=10.
  - jalr: Jump=1, PCTargetALUSrc=1, ResultSrc=10.
  - lui: ALUASrc=10, ImmSrc U.
  - auipc: ALUASrc=01, ImmSrc U.
- Load funct3 011/110/111, store funct3 ≥011, or any unlisted opcode sets IllegalD=1. The bundle is then forced to a bubble: all write/branch/jump enables 0.
- Bubble: RegWrite=0, MemWrite=00, Branch=0, Jump=0, MulDiv=0. Data fields are don't-care; implement them as 0.
- D→E register:
  - Loads the decoded bundle each cycle when not busy.
  - FlushE loads a bubble.
  - While BusyE=1 the register holds and FlushE is ignored.
- E→M register: loads a bubble while BusyE=1, otherwise the E bundle. M→W always loads.
- Divide counter:
  - Loads DIV_CYCLES−1 when a div/divu/rem/remu (MulDiv, funct3[2]=1) loads into E.
  - Decrements while non-zero.
  - BusyE = (cnt≠0).
- Multiply ops are single-cycle: no busy.

## Timing
- All pipeline registers and the counter update on rising clk.
- Reset asserted, at any time including mid-divide: every E/M/W output is 0, ALUControlE=0, cnt=0, BusyE=0. Outputs stay so until the first edge after deassertion.
- Combinational outputs (ImmSrcD, IllegalD) have zero latency. E outputs appear 1 cycle after D, M outputs 2, W outputs 3, absent holds.
- A divide entering E at edge N asserts BusyE from N until edge N+DIV_CYCLES−1. It reaches M at edge N+DIV_CYCLES, and DIV_CYCLES−1 bubbles precede it into M.
- DIV_CYCLES=1: BusyE never asserts.
- A second divide immediately behind a divide reloads the counter only when it actually loads into E, i.e. after release.

## Configuration
- RV32M_EN defined:
  - funct7=0000001 with opcode 0110011 decodes as RV32M: MulDiv=1, MdOp=funct3, ResultSrc=11.
  - The divide counter and BusyE are present.
- Not defined:
  - That encoding sets IllegalD.
  - MulDivE, MdOpE and BusyE are tied 0.
  - No counter is instantiated; E never holds.

## Test plan
- Reset low mid-stream with divide active (cnt=17) → all E/M/W outputs 0, BusyE=0 immediately; first instruction after release appears at E one cycle later.
- add x1,x2,x3 then sw → 1 cycle later ALUControlE=0; 2 cycles later RegWriteM=1; the sw gives MemWriteM=11 at its own M stage; RegWriteW=1 three cycles after add.
- sub/sra/srai/srli → ALUControlE=1/9/9/8; opcode 1111111 → IllegalD=1, bubble in E.
- beq followed by FlushE pulse → bubble in E, RegWriteM=0, BranchE=0 next cycle.
- RV32M_EN, DIV_CYCLES=4, div x5,x6,x7 → BusyE high 3 cycles; E bundle frozen; 3 bubbles into M; div in M at cycle 4 with ResultSrcM=11, RegWriteM=1.
- RV32M_EN off, mul encoding → IllegalD=1, MulDivE=0, BusyE stays 0.
